// File: rtl/ad9910_serial_rx.sv
// AD9910-style serial port receiver: decodes instruction + payload writes from a
// slow asynchronous SPI-like link and double-buffers profile/CFR2 behind IO_UPDATE.
module ad9910_serial_rx #(
    parameter logic [4:0]  P_CFR2_ADDR = 5'h01,
    parameter logic [4:0]  P_PROF_ADDR = 5'h0E,
    parameter int unsigned P_SYNC      = 2
) (
    input  logic        iClk,
    input  logic        iReset_n,
    input  logic        iSCLK,
    input  logic        iSDIO,
    input  logic        iCS_n,
    input  logic        iIOUpdate,
    output logic        oWrValid,
    output logic [4:0]  oWrAddr,
    output logic [63:0] oWrData,
    output logic [31:0] oFrq,
    output logic [15:0] oPhs,
    output logic [13:0] oAmp,
    output logic [31:0] oCFR2,
    output logic        oFrameErr,
    output logic        oBusy
);

    localparam int unsigned LP_CNT_W      = 7;
    localparam int unsigned LP_INSTR_LAST = 7;

    typedef enum logic [1:0] {S_IDLE, S_INSTR, S_DATA, S_DONE} state_t;

    state_t r_state, w_state_nxt;

    logic [P_SYNC-1:0]   r_sclk_s, r_sdio_s, r_cs_s, r_iou_s;
    logic                r_sclk_d, r_cs_d, r_iou_d;
    logic [LP_CNT_W-1:0] r_bitcnt;
    logic [6:0]          r_instr;
    logic [62:0]         r_shift;
    logic                r_rw;
    logic [4:0]          r_addr;
    logic [61:0]         r_prof;
    logic [31:0]         r_cfr2;

    logic        w_sclk, w_sdio, w_cs, w_iou;
    logic        w_sclk_rise, w_cs_fall, w_cs_rise, w_iou_rise, w_bit_en, w_cnt_zero;
    logic [7:0]  w_instr_nxt;
    logic [63:0] w_shift_nxt;
    logic [4:0]  w_nxt_addr;
    logic        w_long;
    logic        w_cnt_reload, w_instr_shift, w_instr_last, w_data_shift, w_frame_end, w_abort;
    logic        w_wr_fire, w_rd_fire, w_prof_ld, w_cfr2_ld;
    logic [61:0] w_prof_nxt;
    logic [31:0] w_cfr2_nxt;

    // Synchronizers and edge-detect history for all asynchronous inputs
    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            r_sclk_s <= '0;
            r_sdio_s <= '0;
            r_cs_s   <= '0;
            r_iou_s  <= '0;
            r_sclk_d <= 1'b0;
            r_cs_d   <= 1'b0;
            r_iou_d  <= 1'b0;
        end else begin
            r_sclk_s <= {r_sclk_s[P_SYNC-2:0], iSCLK};
            r_sdio_s <= {r_sdio_s[P_SYNC-2:0], iSDIO};
            r_cs_s   <= {r_cs_s[P_SYNC-2:0], iCS_n};
            r_iou_s  <= {r_iou_s[P_SYNC-2:0], iIOUpdate};
            r_sclk_d <= w_sclk;
            r_cs_d   <= w_cs;
            r_iou_d  <= w_iou;
        end
    end

    assign w_sclk      = r_sclk_s[P_SYNC-1];
    assign w_sdio      = r_sdio_s[P_SYNC-1];
    assign w_cs        = r_cs_s[P_SYNC-1];
    assign w_iou       = r_iou_s[P_SYNC-1];
    assign w_sclk_rise = w_sclk & ~r_sclk_d;
    assign w_cs_fall   = ~w_cs & r_cs_d;
    assign w_cs_rise   = w_cs & ~r_cs_d;
    assign w_iou_rise  = w_iou & ~r_iou_d;
    assign w_bit_en    = w_sclk_rise & ~w_cs;
    assign w_cnt_zero  = (r_bitcnt == '0);

    assign w_instr_nxt = {r_instr, w_sdio};
    assign w_shift_nxt = {r_shift, w_sdio};
    assign w_nxt_addr  = w_instr_nxt[4:0];
    assign w_long      = (w_nxt_addr >= 5'h0E) && (w_nxt_addr <= 5'h15);

    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) r_state <= S_IDLE;
        else           r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_cs_fall) w_state_nxt = S_INSTR;
            S_INSTR: if (w_cs_rise) w_state_nxt = S_IDLE;
                     else if (w_bit_en && w_cnt_zero) w_state_nxt = S_DATA;
            S_DATA:  if (w_cs_rise) w_state_nxt = S_IDLE;
                     else if (w_bit_en && w_cnt_zero) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = w_cs ? S_IDLE : S_INSTR;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // A CS rise in S_INSTR with no bits received closes a frame cleanly; only partial frames are errors
    always_comb begin
        w_cnt_reload  = 1'b0;
        w_instr_shift = 1'b0;
        w_instr_last  = 1'b0;
        w_data_shift  = 1'b0;
        w_frame_end   = 1'b0;
        w_abort       = 1'b0;
        case (r_state)
            S_IDLE:  w_cnt_reload = 1'b1;
            S_INSTR: if (w_cs_rise) begin
                         w_abort = (r_bitcnt != LP_CNT_W'(LP_INSTR_LAST));
                     end else if (w_bit_en) begin
                         w_instr_shift = 1'b1;
                         w_instr_last  = w_cnt_zero;
                     end
            S_DATA:  if (w_cs_rise) begin
                         w_abort = 1'b1;
                     end else if (w_bit_en) begin
                         w_data_shift = 1'b1;
                         w_frame_end  = w_cnt_zero;
                     end
            S_DONE:  w_cnt_reload = 1'b1;
            default: w_cnt_reload = 1'b1;
        endcase
    end

    assign w_wr_fire  = w_frame_end & ~r_rw;
    assign w_rd_fire  = w_frame_end & r_rw;
    assign w_prof_ld  = w_wr_fire && (r_addr == P_PROF_ADDR);
    assign w_cfr2_ld  = w_wr_fire && (r_addr == P_CFR2_ADDR);
    assign w_prof_nxt = w_prof_ld ? w_shift_nxt[61:0] : r_prof;
    assign w_cfr2_nxt = w_cfr2_ld ? w_shift_nxt[31:0] : r_cfr2;

    // Bit counter and instruction/payload shift registers
    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            r_bitcnt <= LP_CNT_W'(LP_INSTR_LAST);
            r_instr  <= '0;
            r_shift  <= '0;
            r_rw     <= 1'b0;
            r_addr   <= '0;
        end else if (w_cnt_reload) begin
            r_bitcnt <= LP_CNT_W'(LP_INSTR_LAST);
        end else if (w_instr_shift) begin
            r_instr <= w_instr_nxt[6:0];
            if (w_instr_last) begin
                r_bitcnt <= w_long ? 7'd63 : 7'd31;
                r_rw     <= w_instr_nxt[7];
                r_addr   <= w_nxt_addr;
                r_shift  <= '0;
            end else begin
                r_bitcnt <= r_bitcnt - 7'd1;
            end
        end else if (w_data_shift) begin
            r_shift  <= w_shift_nxt[62:0];
            r_bitcnt <= r_bitcnt - 7'd1;
        end
    end

    // Write port, shadows, and IO_UPDATE commit (forwarding a same-cycle shadow load)
    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            oWrValid  <= 1'b0;
            oWrAddr   <= '0;
            oWrData   <= '0;
            oFrameErr <= 1'b0;
            oBusy     <= 1'b0;
            r_prof    <= '0;
            r_cfr2    <= '0;
            oFrq      <= '0;
            oPhs      <= '0;
            oAmp      <= '0;
            oCFR2     <= '0;
        end else begin
            oWrValid  <= w_wr_fire;
            oFrameErr <= w_abort | w_rd_fire;
            oBusy     <= (w_state_nxt != S_IDLE);
            if (w_wr_fire) begin
                oWrAddr <= r_addr;
                oWrData <= w_shift_nxt;
            end
            r_prof <= w_prof_nxt;
            r_cfr2 <= w_cfr2_nxt;
            if (w_iou_rise) begin
                oFrq  <= w_prof_nxt[31:0];
                oPhs  <= w_prof_nxt[47:32];
                oAmp  <= w_prof_nxt[61:48];
                oCFR2 <= w_cfr2_nxt;
            end
        end
    end

endmodule

// File: tb/tb_ad9910_serial_rx.sv
// Randomized self-checking bench for ad9910_serial_rx against a transaction-level model.
module tb_ad9910_serial_rx;

    localparam int unsigned SYNC = 2;

    logic        iClk = 1'b0;
    logic        iReset_n = 1'b0;
    logic        iSCLK = 1'b0;
    logic        iSDIO = 1'b0;
    logic        iCS_n = 1'b1;
    logic        iIOUpdate = 1'b0;
    logic        oWrValid;
    logic [4:0]  oWrAddr;
    logic [63:0] oWrData;
    logic [31:0] oFrq;
    logic [15:0] oPhs;
    logic [13:0] oAmp;
    logic [31:0] oCFR2;
    logic        oFrameErr;
    logic        oBusy;

    ad9910_serial_rx #(.P_CFR2_ADDR(5'h01), .P_PROF_ADDR(5'h0E), .P_SYNC(SYNC)) dut (
        .iClk(iClk), .iReset_n(iReset_n), .iSCLK(iSCLK), .iSDIO(iSDIO), .iCS_n(iCS_n),
        .iIOUpdate(iIOUpdate), .oWrValid(oWrValid), .oWrAddr(oWrAddr), .oWrData(oWrData),
        .oFrq(oFrq), .oPhs(oPhs), .oAmp(oAmp), .oCFR2(oCFR2), .oFrameErr(oFrameErr), .oBusy(oBusy)
    );

    always #5 iClk = ~iClk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [63:0] m_prof = '0;
    logic [31:0] m_cfr2 = '0;
    logic [31:0] m_frq  = '0;
    logic [15:0] m_phs  = '0;
    logic [13:0] m_amp  = '0;
    logic [31:0] m_cfr2_act = '0;
    logic [4:0]  exp_addr_q[$];
    logic [63:0] exp_data_q[$];
    int          exp_err = 0;

    // Observed pulses
    logic [4:0]  mon_addr_q[$];
    logic [63:0] mon_data_q[$];
    int          mon_err = 0;

    always @(negedge iClk) begin
        if (iReset_n) begin
            if (oWrValid) begin
                mon_addr_q.push_back(oWrAddr);
                mon_data_q.push_back(oWrData);
            end
            if (oFrameErr) mon_err++;
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int plen(input logic [4:0] a);
        return (a >= 5'h0E && a <= 5'h15) ? 64 : 32;
    endfunction

    task automatic sclk_bit(input logic b);
        @(negedge iClk);
        iSDIO = b;
        repeat (4) @(negedge iClk);
        iSCLK = 1'b1;
        repeat (4) @(negedge iClk);
        iSCLK = 1'b0;
    endtask

    task automatic send_stream(input logic [7:0] instr, input logic [63:0] data, input int ntotal);
        int len;
        len = plen(instr[4:0]);
        for (int i = 0; i < ntotal; i++)
            sclk_bit(i < 8 ? instr[7-i] : data[len-1-(i-8)]);
    endtask

    // Expected outcome of one transaction of ntotal bits (fewer than a full frame = aborted)
    task automatic model_txn(input logic [7:0] instr, input logic [63:0] data, input int ntotal);
        int          len;
        logic [63:0] d;
        len = plen(instr[4:0]);
        if (ntotal < 8 + len) begin
            if (ntotal > 0) exp_err++;
        end else if (instr[7]) begin
            exp_err++;
        end else begin
            d = (len == 32) ? {32'h0, data[31:0]} : data;
            exp_addr_q.push_back(instr[4:0]);
            exp_data_q.push_back(d);
            if (instr[4:0] == 5'h0E) m_prof = d;
            if (instr[4:0] == 5'h01) m_cfr2 = d[31:0];
        end
    endtask

    task automatic txn(input logic [7:0] instr, input logic [63:0] data, input int ntotal);
        model_txn(instr, data, ntotal);
        send_stream(instr, data, ntotal);
    endtask

    task automatic model_commit();
        m_frq = m_prof[31:0];
        m_phs = m_prof[47:32];
        m_amp = m_prof[61:48];
        m_cfr2_act = m_cfr2;
    endtask

    task automatic cs_low();
        @(negedge iClk);
        iCS_n = 1'b0;
        repeat (4) @(negedge iClk);
    endtask

    task automatic cs_high();
        @(negedge iClk);
        iCS_n = 1'b1;
        repeat (6) @(negedge iClk);
    endtask

    task automatic io_update();
        @(negedge iClk);
        iIOUpdate = 1'b1;
        repeat (4) @(negedge iClk);
        iIOUpdate = 1'b0;
        repeat (6) @(negedge iClk);
        model_commit();
    endtask

    task automatic test_reset();
        repeat (5) @(negedge iClk);
        n_checks++;
        if ({oWrValid, oWrAddr, oWrData, oFrq, oPhs, oAmp, oCFR2, oFrameErr, oBusy} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got wr=%b addr=%h data=%h frq=%h phs=%h amp=%h cfr2=%h err=%b busy=%b expected all 0",
                     oWrValid, oWrAddr, oWrData, oFrq, oPhs, oAmp, oCFR2, oFrameErr, oBusy);
        end
        iReset_n = 1'b1;
        repeat (8) @(negedge iClk);
        n_checks++;
        if ({oWrValid, oFrameErr, oBusy} !== 3'b000) begin
            n_fail++;
            $display("FAIL idle_after_reset: got wr/err/busy=%b expected 000", {oWrValid, oFrameErr, oBusy});
        end
    endtask

    task automatic test_cfr2_write();
        cs_low();
        n_checks++;
        if (oBusy !== 1'b1) begin n_fail++; $display("FAIL busy_in_frame: got %b expected 1", oBusy); end
        txn(8'h01, 64'h0140_0820, 40);
        cs_high();
        n_checks++;
        if (oBusy !== 1'b0) begin n_fail++; $display("FAIL busy_after_cs: got %b expected 0", oBusy); end
        n_checks++;
        if (mon_addr_q.size() != 1) begin
            n_fail++; $display("FAIL cfr2_wr_count: got %0d expected 1", mon_addr_q.size());
        end else begin
            n_checks++;
            if (mon_addr_q[0] !== 5'h01) begin n_fail++; $display("FAIL cfr2_wr_addr: got %h expected 01", mon_addr_q[0]); end
            n_checks++;
            if (mon_data_q[0] !== 64'h0000_0000_0140_0820) begin
                n_fail++; $display("FAIL cfr2_wr_data: got %h expected 0000000001400820", mon_data_q[0]);
            end
        end
        n_checks++;
        if (oCFR2 !== 32'h0) begin n_fail++; $display("FAIL cfr2_before_update: got %h expected 0", oCFR2); end
        io_update();
        n_checks++;
        if (oCFR2 !== 32'h0140_0820) begin n_fail++; $display("FAIL cfr2_after_update: got %h expected 01400820", oCFR2); end
        mon_addr_q.delete(); mon_data_q.delete(); exp_addr_q.delete(); exp_data_q.delete();
    endtask

    task automatic test_profile_write();
        cs_low();
        txn(8'h0E, {2'b00, 14'h3FFF, 16'h1234, 32'h1999_9999}, 72);
        cs_high();
        n_checks++;
        if (mon_addr_q.size() != 1 || mon_addr_q[0] !== 5'h0E) begin
            n_fail++; $display("FAIL prof_wr: got %0d pulses expected 1 at addr 0e", mon_addr_q.size());
        end
        n_checks++;
        if ({oAmp, oPhs, oFrq} !== '0) begin
            n_fail++; $display("FAIL prof_before_update: got amp=%h phs=%h frq=%h expected 0", oAmp, oPhs, oFrq);
        end
        io_update();
        n_checks++;
        if ({oAmp, oPhs, oFrq} !== {14'h3FFF, 16'h1234, 32'h1999_9999}) begin
            n_fail++; $display("FAIL prof_after_update: got amp=%h phs=%h frq=%h expected 3fff 1234 19999999", oAmp, oPhs, oFrq);
        end
        mon_addr_q.delete(); mon_data_q.delete(); exp_addr_q.delete(); exp_data_q.delete();
    endtask

    task automatic test_abort();
        int err0;
        err0 = mon_err;
        cs_low();
        txn(8'h0E, {$urandom, $urandom}, 28);
        cs_high();
        io_update();
        n_checks++;
        if (mon_err - err0 != 1) begin n_fail++; $display("FAIL abort_err_pulses: got %0d expected 1", mon_err - err0); end
        n_checks++;
        if (mon_addr_q.size() != 0) begin n_fail++; $display("FAIL abort_no_wr: got %0d pulses expected 0", mon_addr_q.size()); end
        n_checks++;
        if ({oAmp, oPhs, oFrq} !== {m_amp, m_phs, m_frq}) begin
            n_fail++; $display("FAIL abort_shadow: got %h%h%h expected %h%h%h", oAmp, oPhs, oFrq, m_amp, m_phs, m_frq);
        end
        mon_addr_q.delete(); mon_data_q.delete();
    endtask

    task automatic test_read();
        int err0;
        err0 = mon_err;
        cs_low();
        txn(8'h81, {32'h0, $urandom}, 40);
        cs_high();
        io_update();
        n_checks++;
        if (mon_err - err0 != 1) begin n_fail++; $display("FAIL read_err_pulses: got %0d expected 1", mon_err - err0); end
        n_checks++;
        if (mon_addr_q.size() != 0) begin n_fail++; $display("FAIL read_no_wr: got %0d pulses expected 0", mon_addr_q.size()); end
        n_checks++;
        if (oCFR2 !== m_cfr2_act) begin n_fail++; $display("FAIL read_cfr2: got %h expected %h", oCFR2, m_cfr2_act); end
        mon_addr_q.delete(); mon_data_q.delete();
    endtask

    task automatic test_back_to_back();
        cs_low();
        txn(8'h01, {32'h0, $urandom}, 40);
        txn(8'h0E, {$urandom, $urandom}, 72);
        txn(8'h13, {$urandom, $urandom}, 72);
        cs_high();
        io_update();
        n_checks++;
        if (mon_addr_q.size() != exp_addr_q.size()) begin
            n_fail++; $display("FAIL b2b_count: got %0d expected %0d", mon_addr_q.size(), exp_addr_q.size());
        end else begin
            foreach (exp_addr_q[i]) begin
                n_checks++;
                if (mon_addr_q[i] !== exp_addr_q[i] || mon_data_q[i] !== exp_data_q[i]) begin
                    n_fail++; $display("FAIL b2b_wr%0d: got %h/%h expected %h/%h", i, mon_addr_q[i], mon_data_q[i], exp_addr_q[i], exp_data_q[i]);
                end
            end
        end
        n_checks++;
        if ({oAmp, oPhs, oFrq, oCFR2} !== {m_amp, m_phs, m_frq, m_cfr2_act}) begin
            n_fail++; $display("FAIL b2b_active: got %h%h%h %h expected %h%h%h %h", oAmp, oPhs, oFrq, oCFR2, m_amp, m_phs, m_frq, m_cfr2_act);
        end
        mon_addr_q.delete(); mon_data_q.delete(); exp_addr_q.delete(); exp_data_q.delete();
    endtask

    // Final SCLK edge and IO_UPDATE edge arrive together: checks latency and same-cycle commit
    task automatic test_latency_commit();
        logic [31:0] v;
        logic [7:0]  instr;
        int          cyc;
        v = $urandom;
        instr = 8'h01;
        model_txn(instr, {32'h0, v}, 40);
        model_commit();
        cs_low();
        for (int i = 0; i < 39; i++) sclk_bit(i < 8 ? instr[7-i] : v[31-(i-8)]);
        @(negedge iClk);
        iSDIO = v[0];
        repeat (4) @(negedge iClk);
        iSCLK = 1'b1;
        iIOUpdate = 1'b1;
        cyc = 0;
        for (int k = 1; k <= 20 && cyc == 0; k++) begin
            @(posedge iClk);
            #1;
            if (oWrValid) cyc = k;
        end
        n_checks++;
        if (cyc != int'(SYNC) + 1) begin n_fail++; $display("FAIL wr_latency: got %0d cycles expected %0d", cyc, SYNC + 1); end
        repeat (4) @(negedge iClk);
        iSCLK = 1'b0;
        iIOUpdate = 1'b0;
        cs_high();
        n_checks++;
        if (oCFR2 !== m_cfr2_act) begin n_fail++; $display("FAIL same_cycle_commit: got %h expected %h", oCFR2, m_cfr2_act); end
        n_checks++;
        if (mon_addr_q.size() != 1 || mon_data_q[0] !== exp_data_q[0]) begin
            n_fail++; $display("FAIL latency_wr: got %0d pulses expected 1 with data %h", mon_addr_q.size(), exp_data_q[0]);
        end
        mon_addr_q.delete(); mon_data_q.delete(); exp_addr_q.delete(); exp_data_q.delete();
    endtask

    task automatic test_reset_mid_frame();
        int err0;
        cs_low();
        send_stream(8'h0E, {$urandom, $urandom}, 30);
        @(negedge iClk);
        iReset_n = 1'b0;
        m_prof = '0; m_cfr2 = '0;
        model_commit();
        repeat (3) @(negedge iClk);
        n_checks++;
        if ({oWrValid, oWrAddr, oWrData, oFrq, oPhs, oAmp, oCFR2, oFrameErr, oBusy} !== '0) begin
            n_fail++; $display("FAIL reset_mid_frame: got busy=%b cfr2=%h frq=%h wrdata=%h expected all 0", oBusy, oCFR2, oFrq, oWrData);
        end
        iReset_n = 1'b1;
        err0 = mon_err;
        for (int i = 0; i < 42; i++) sclk_bit(1'($urandom));
        cs_high();
        n_checks++;
        if (mon_addr_q.size() != 0 || mon_err != err0 || oBusy !== 1'b0) begin
            n_fail++; $display("FAIL post_reset_ignore: got wr=%0d err=%0d busy=%b expected 0 0 0", mon_addr_q.size(), mon_err - err0, oBusy);
        end
        cs_low();
        txn(8'h0E, {$urandom, $urandom}, 72);
        cs_high();
        io_update();
        n_checks++;
        if (mon_addr_q.size() != 1 || mon_data_q[0] !== exp_data_q[0]) begin
            n_fail++; $display("FAIL post_reset_frame: got %0d pulses expected 1 with data %h", mon_addr_q.size(), exp_data_q[0]);
        end
        n_checks++;
        if ({oAmp, oPhs, oFrq} !== {m_amp, m_phs, m_frq}) begin
            n_fail++; $display("FAIL post_reset_active: got %h%h%h expected %h%h%h", oAmp, oPhs, oFrq, m_amp, m_phs, m_frq);
        end
        mon_addr_q.delete(); mon_data_q.delete(); exp_addr_q.delete(); exp_data_q.delete();
    endtask

    task automatic test_random();
        logic [7:0]  instr;
        logic [63:0] data;
        int          len, ntot;
        for (int it = 0; it < 12; it++) begin
            case ($urandom_range(0, 2))
                0:       instr[4:0] = 5'h01;
                1:       instr[4:0] = 5'h0E;
                default: instr[4:0] = 5'($urandom_range(0, 31));
            endcase
            instr[6:5] = 2'($urandom);
            instr[7]   = ($urandom_range(0, 4) == 0);
            data = {$urandom, $urandom};
            len  = plen(instr[4:0]);
            ntot = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 7 + len)) : 8 + len;
            cs_low();
            txn(instr, data, ntot);
            cs_high();
            if ($urandom_range(0, 1) == 1) io_update();
            n_checks++;
            if (mon_addr_q.size() != exp_addr_q.size()) begin
                n_fail++; $display("FAIL rnd%0d_count: got %0d expected %0d", it, mon_addr_q.size(), exp_addr_q.size());
            end else begin
                foreach (exp_addr_q[i]) begin
                    n_checks++;
                    if (mon_addr_q[i] !== exp_addr_q[i] || mon_data_q[i] !== exp_data_q[i]) begin
                        n_fail++; $display("FAIL rnd%0d_wr: got %h/%h expected %h/%h", it, mon_addr_q[i], mon_data_q[i], exp_addr_q[i], exp_data_q[i]);
                    end
                end
            end
            n_checks++;
            if (mon_err != exp_err) begin n_fail++; $display("FAIL rnd%0d_err: got %0d expected %0d", it, mon_err, exp_err); end
            n_checks++;
            if ({oAmp, oPhs, oFrq, oCFR2} !== {m_amp, m_phs, m_frq, m_cfr2_act}) begin
                n_fail++; $display("FAIL rnd%0d_active: got %h%h%h %h expected %h%h%h %h", it, oAmp, oPhs, oFrq, oCFR2, m_amp, m_phs, m_frq, m_cfr2_act);
            end
            mon_addr_q.delete(); mon_data_q.delete(); exp_addr_q.delete(); exp_data_q.delete();
        end
    endtask

    initial begin
        test_reset();
        test_cfr2_write();
        test_profile_write();
        test_abort();
        test_read();
        test_back_to_back();
        test_latency_commit();
        test_reset_mid_frame();
        exp_err = mon_err;
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
